// File: rtl/multicycle_control_fsm_if.sv
// Control/handshake bundle between the multicycle control FSM and the CPU datapath/memory.
// The counter outputs exist only when CTRL_CYCLE_COUNT_EN is defined.
interface multicycle_control_fsm_if #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3
`ifdef CTRL_CYCLE_COUNT_EN
  , parameter int CNT_W  = 16
`endif
);
  logic                start;
  logic                mem_ready;
  logic [OPCODE_W-1:0] opcode;
  logic                alu_zero;

  logic                mem_req;
  logic                mem_we;
  logic                ir_load;
  logic                pc_inc;
  logic                pc_load;
  logic                alu_en;
  logic [ALU_OP_W-1:0] alu_op;
  logic                reg_we;
  logic                busy;
  logic                halted;
  logic                instr_done;
  logic                illegal_op;
`ifdef CTRL_CYCLE_COUNT_EN
  logic [CNT_W-1:0]    cycle_cnt;
  logic [CNT_W-1:0]    instr_cnt;
`endif

  modport master (
    input  start, mem_ready, opcode, alu_zero,
    output mem_req, mem_we, ir_load, pc_inc, pc_load, alu_en, alu_op,
           reg_we, busy, halted, instr_done, illegal_op
`ifdef CTRL_CYCLE_COUNT_EN
    , output cycle_cnt, instr_cnt
`endif
  );

  modport slave (
    output start, mem_ready, opcode, alu_zero,
    input  mem_req, mem_we, ir_load, pc_inc, pc_load, alu_en, alu_op,
           reg_we, busy, halted, instr_done, illegal_op
`ifdef CTRL_CYCLE_COUNT_EN
    , input cycle_cnt, instr_cnt
`endif
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory ready handshake.
// Optional busy-cycle / retired-instruction counters are enabled by defining CTRL_CYCLE_COUNT_EN.
module multicycle_control_fsm #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3
`ifdef CTRL_CYCLE_COUNT_EN
  , parameter int CNT_W  = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_LAST = OPCODE_W'(6);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                opcode_illegal;

  assign opcode_illegal = (bus.opcode > OP_LAST);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = bus.opcode;
        if (opcode_illegal)             state_d = S_FETCH;
        else if (bus.opcode == OP_HALT) state_d = S_HALT;
        else                            state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD, OP_AND: state_d = S_WB;
          OP_LD, OP_ST:   state_d = S_MEM;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready) state_d = (op_q == OP_ST) ? S_FETCH : S_WB;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Outputs decode from the registered state; only the handshake/flag terms look at live inputs.
  logic                mem_req, mem_we, ir_load, pc_inc, pc_load, alu_en;
  logic [ALU_OP_W-1:0] alu_op;
  logic                reg_we, instr_done, illegal_op;

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    alu_en     = 1'b0;
    alu_op     = '0;
    reg_we     = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = bus.mem_ready;
        pc_inc  = bus.mem_ready;
      end
      S_DECODE: begin
        illegal_op = opcode_illegal;
        instr_done = opcode_illegal;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if (op_q == OP_AND)      alu_op = ALU_OP_W'(1);
        else if (op_q == OP_BEQ) alu_op = ALU_OP_W'(2);
        pc_load    = (op_q == OP_JMP) || ((op_q == OP_BEQ) && bus.alu_zero);
        instr_done = (op_q == OP_JMP) || (op_q == OP_BEQ);
      end
      S_MEM: begin
        mem_req    = 1'b1;
        mem_we     = (op_q == OP_ST);
        instr_done = (op_q == OP_ST) && bus.mem_ready;
      end
      S_WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.ir_load    = ir_load;
  assign bus.pc_inc     = pc_inc;
  assign bus.pc_load    = pc_load;
  assign bus.alu_en     = alu_en;
  assign bus.alu_op     = alu_op;
  assign bus.reg_we     = reg_we;
  assign bus.instr_done = instr_done;
  assign bus.illegal_op = illegal_op;
  assign bus.busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted     = (state_q == S_HALT);

`ifdef CTRL_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (bus.busy && !(&cycle_cnt_q)) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if (instr_done && !(&instr_cnt_q)) instr_cnt_d = instr_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.instr_cnt = instr_cnt_q;
`endif

endmodule
